// File: rtl/dlx_mc_control.sv
// dlx_mc_control: multicycle control FSM for the DLX core (fetch/decode/execute/memory/writeback).
// Define DLX_JR_EN to decode JR/JALR (opcodes 0x12/0x13) through the JUMP state; otherwise they trap to HALT.
module dlx_mc_control (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr,
  input  logic        mem_ready,
  input  logic        alu_zero,
  output logic [3:0]  alu_ctrl,
  output logic        op_swap,
  output logic        alusrc_a,
  output logic [2:0]  alusrc_b,
  output logic        pc_we,
  output logic        ir_we,
  output logic        ab_we,
  output logic        aluout_we,
  output logic        mdr_we,
  output logic        reg_we,
  output logic [1:0]  pc_src,
  output logic        iord,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [1:0]  reg_dst,
  output logic [1:0]  wb_src,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EX_R, S_EX_I, S_MEM_ADDR, S_MEM_LD,
    S_MEM_ST, S_WB_ALU, S_WB_LD, S_BRANCH, S_JUMP, S_HALT
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010, ALU_OR  = 4'b0011;
  localparam logic [3:0] ALU_XOR = 4'b0100, ALU_SLL = 4'b0101, ALU_SRL = 4'b0110, ALU_SRA = 4'b0111;
  localparam logic [3:0] ALU_SEQ = 4'b1000, ALU_SNE = 4'b1001, ALU_SLT = 4'b1010, ALU_SLE = 4'b1011;
  localparam logic [3:0] ALU_SGT = 4'b1100, ALU_SGE = 4'b1101, ALU_LHI = 4'b1110, ALU_NOP = 4'b1111;

  localparam logic [2:0] SRCB_B = 3'b000, SRCB_FOUR = 3'b001, SRCB_SEXT16 = 3'b010;
  localparam logic [2:0] SRCB_ZEXT16 = 3'b011, SRCB_SEXT26 = 3'b100, SRCB_ZERO = 3'b101;

  state_t      r_state;
  logic [5:0]  w_opcode;
  logic [5:0]  w_func;
  logic        w_r_ok;
  logic [3:0]  w_r_ctrl;
  logic        w_i_ok;
  logic [3:0]  w_i_ctrl;
  logic [2:0]  w_i_srcb;
  logic        w_jr;
  logic        w_link;
  logic        w_jump;
  logic        w_take;

  // {valid, alu code} for R-type func field
  function automatic logic [4:0] r_decode(input logic [5:0] f);
    case (f)
      6'h20, 6'h21: r_decode = {1'b1, ALU_ADD};
      6'h22, 6'h23: r_decode = {1'b1, ALU_SUB};
      6'h24:        r_decode = {1'b1, ALU_AND};
      6'h25:        r_decode = {1'b1, ALU_OR};
      6'h26:        r_decode = {1'b1, ALU_XOR};
      6'h04:        r_decode = {1'b1, ALU_SLL};
      6'h06:        r_decode = {1'b1, ALU_SRL};
      6'h07:        r_decode = {1'b1, ALU_SRA};
      6'h28:        r_decode = {1'b1, ALU_SEQ};
      6'h29:        r_decode = {1'b1, ALU_SNE};
      6'h2A:        r_decode = {1'b1, ALU_SLT};
      6'h2B:        r_decode = {1'b1, ALU_SGT};
      6'h2C:        r_decode = {1'b1, ALU_SLE};
      6'h2D:        r_decode = {1'b1, ALU_SGE};
      default:      r_decode = {1'b0, ALU_NOP};
    endcase
  endfunction

  // {valid, alu code, operand-B select} for immediate ALU opcodes
  function automatic logic [7:0] i_decode(input logic [5:0] op);
    case (op)
      6'h08:        i_decode = {1'b1, ALU_ADD, SRCB_SEXT16};
      6'h09:        i_decode = {1'b1, ALU_ADD, SRCB_ZEXT16};
      6'h0A, 6'h0B: i_decode = {1'b1, ALU_SUB, SRCB_SEXT16};
      6'h0C:        i_decode = {1'b1, ALU_AND, SRCB_ZEXT16};
      6'h0D:        i_decode = {1'b1, ALU_OR,  SRCB_ZEXT16};
      6'h0E:        i_decode = {1'b1, ALU_XOR, SRCB_ZEXT16};
      6'h0F:        i_decode = {1'b1, ALU_LHI, SRCB_ZEXT16};
      6'h14:        i_decode = {1'b1, ALU_SLL, SRCB_SEXT16};
      6'h16:        i_decode = {1'b1, ALU_SRL, SRCB_SEXT16};
      6'h17:        i_decode = {1'b1, ALU_SRA, SRCB_SEXT16};
      6'h18:        i_decode = {1'b1, ALU_SEQ, SRCB_SEXT16};
      6'h19:        i_decode = {1'b1, ALU_SNE, SRCB_SEXT16};
      6'h1A:        i_decode = {1'b1, ALU_SLT, SRCB_SEXT16};
      6'h1B:        i_decode = {1'b1, ALU_SGT, SRCB_SEXT16};
      6'h1C:        i_decode = {1'b1, ALU_SLE, SRCB_SEXT16};
      6'h1D:        i_decode = {1'b1, ALU_SGE, SRCB_SEXT16};
      default:      i_decode = {1'b0, ALU_NOP, SRCB_B};
    endcase
  endfunction

  assign w_opcode = instr[31:26];
  assign w_func   = instr[5:0];
  assign {w_r_ok, w_r_ctrl} = r_decode(w_func);
  assign {w_i_ok, w_i_ctrl, w_i_srcb} = i_decode(w_opcode);

`ifdef DLX_JR_EN
  assign w_jr   = (w_opcode == 6'h12) || (w_opcode == 6'h13);
  assign w_link = (w_opcode == 6'h03) || (w_opcode == 6'h13);
`else
  assign w_jr   = 1'b0;
  assign w_link = (w_opcode == 6'h03);
`endif
  assign w_jump = (w_opcode == 6'h02) || (w_opcode == 6'h03) || w_jr;
  assign w_take = ((w_opcode == 6'h04) && alu_zero) || ((w_opcode == 6'h05) && !alu_zero);

  // State register and next-state sequencing
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_FETCH;
    end else begin
      case (r_state)
        S_FETCH:    if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          if (w_opcode == 6'h00)                            r_state <= S_EX_R;
          else if (w_i_ok)                                  r_state <= S_EX_I;
          else if (w_opcode == 6'h23 || w_opcode == 6'h2B)  r_state <= S_MEM_ADDR;
          else if (w_opcode == 6'h04 || w_opcode == 6'h05)  r_state <= S_BRANCH;
          else if (w_jump)                                  r_state <= S_JUMP;
          else                                              r_state <= S_HALT;
        end
        S_EX_R:     r_state <= w_r_ok ? S_WB_ALU : S_HALT;
        S_EX_I:     r_state <= S_WB_ALU;
        S_MEM_ADDR: r_state <= (w_opcode == 6'h2B) ? S_MEM_ST : S_MEM_LD;
        S_MEM_LD:   if (mem_ready) r_state <= S_WB_LD;
        S_MEM_ST:   if (mem_ready) r_state <= S_FETCH;
        S_WB_ALU, S_WB_LD, S_BRANCH, S_JUMP: r_state <= S_FETCH;
        S_HALT:     r_state <= S_HALT;
        default:    r_state <= S_FETCH;
      endcase
    end
  end

  // Datapath controls decoded from state and IR; reset forces the idle pattern
  always_comb begin
    alu_ctrl  = ALU_NOP;
    op_swap   = 1'b0;
    alusrc_a  = 1'b0;
    alusrc_b  = SRCB_B;
    pc_we     = 1'b0;
    ir_we     = 1'b0;
    ab_we     = 1'b0;
    aluout_we = 1'b0;
    mdr_we    = 1'b0;
    reg_we    = 1'b0;
    pc_src    = 2'b00;
    iord      = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    reg_dst   = 2'b00;
    wb_src    = 2'b00;
    halted    = 1'b0;
    if (reset) begin
      halted = 1'b0;
    end else begin
      case (r_state)
        S_FETCH: begin
          mem_rd   = 1'b1;
          alu_ctrl = ALU_ADD;
          alusrc_b = SRCB_FOUR;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end else begin
            ir_we = 1'b0;
          end
        end
        S_DECODE: begin
          ab_we     = 1'b1;
          aluout_we = 1'b1;
          alu_ctrl  = ALU_ADD;
          alusrc_b  = SRCB_SEXT16;
        end
        S_EX_R: begin
          if (w_r_ok) begin
            alu_ctrl  = w_r_ctrl;
            op_swap   = (w_r_ctrl == ALU_SUB);
            alusrc_a  = 1'b1;
            aluout_we = 1'b1;
          end else begin
            alu_ctrl  = ALU_NOP;
          end
        end
        S_EX_I: begin
          alu_ctrl  = w_i_ctrl;
          op_swap   = (w_i_ctrl == ALU_SUB);
          alusrc_a  = 1'b1;
          alusrc_b  = w_i_srcb;
          aluout_we = 1'b1;
        end
        S_WB_ALU: begin
          reg_we  = 1'b1;
          reg_dst = (w_opcode == 6'h00) ? 2'b00 : 2'b01;
        end
        S_MEM_ADDR: begin
          alu_ctrl  = ALU_ADD;
          alusrc_a  = 1'b1;
          alusrc_b  = SRCB_SEXT16;
          aluout_we = 1'b1;
        end
        S_MEM_LD: begin
          mem_rd = 1'b1;
          iord   = 1'b1;
          mdr_we = mem_ready;
        end
        S_MEM_ST: begin
          mem_wr = 1'b1;
          iord   = 1'b1;
        end
        S_WB_LD: begin
          reg_we  = 1'b1;
          reg_dst = 2'b01;
          wb_src  = 2'b01;
        end
        S_BRANCH: begin
          alu_ctrl = ALU_OR;
          alusrc_a = 1'b1;
          alusrc_b = SRCB_ZERO;
          if (w_take) begin
            pc_we  = 1'b1;
            pc_src = 2'b01;
          end else begin
            pc_we  = 1'b0;
          end
        end
        S_JUMP: begin
          pc_we = 1'b1;
          if (w_jr) begin
            pc_src   = 2'b10;
          end else begin
            alu_ctrl = ALU_ADD;
            alusrc_b = SRCB_SEXT26;
          end
          if (w_link) begin
            reg_we  = 1'b1;
            reg_dst = 2'b10;
            wb_src  = 2'b10;
          end else begin
            reg_we  = 1'b0;
          end
        end
        S_HALT:  halted = 1'b1;
        default: halted = 1'b0;
      endcase
    end
  end

endmodule
